tx_scheduler: RTL and testbench
===============================

TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clock and Reset.
REQ-002 Parameter BACKOFF_UNIT, default 512: clock cycles per backoff slot.
REQ-003 Parameter MAX_ATTEMPTS, default 4: busy-channel checks allowed before a message is dropped.
REQ-004 Parameter DONE_TIMEOUT, default 65536: maximum cycles in WAIT_DONE before a message is dropped.
REQ-005 Clock  input  1  system clock; all state updates occur on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 MsgData  input  32  outgoing game message.
REQ-008 MsgValid  input  1  MsgData is valid this cycle.
REQ-009 MsgReady  output  1  the queue accepts a message this cycle.
REQ-010 CCA  input  1  radio clear-channel assessment; 1 means the channel is clear.
REQ-011 TxRequest  output  1  drives the transmit FSM InRequest.
REQ-012 TxData  output  32  drives the transmit FSM DIn; equals the queue head.
REQ-013 TxTaken  input  1  the transmit FSM InValid; a 1-cycle pulse meaning DIn has been latched.
REQ-014 TransmitDone  input  1  the transmit FSM reports that the frame has been sent.
REQ-015 Dropped  output  1  1-cycle pulse when a message is discarded.
REQ-016 QueueCount  output  2  number of queued messages (0-2).
REQ-017 State  output  3  current state encoding.

Function
REQ-018 The queue SHALL be a 2-entry FIFO; MsgReady = (QueueCount != 2); a push occurs when MsgValid and MsgReady are both 1.
REQ-019 A push and a pop in the same cycle SHALL leave QueueCount unchanged and preserve order; a push while full SHALL be ignored.
REQ-020 State encodings SHALL be: IDLE=0, BACKOFF=1, SENSE=2, REQUEST=3, WAIT_DONE=4, DROP=5; values 6-7 SHALL go to IDLE on the next edge.
REQ-021 IDLE: when QueueCount != 0, go to BACKOFF, clear the attempt counter, and load the backoff counter with (LFSR[2:0]+1)*BACKOFF_UNIT-1.
REQ-022 BACKOFF: decrement the counter every cycle; at 0, go to SENSE.
REQ-023 SENSE: if CCA=1, go to REQUEST; otherwise increment attempts.
REQ-024 SENSE (continued): when attempts+1 == MAX_ATTEMPTS, go to DROP; otherwise reload the backoff counter as in REQ-021 and go to BACKOFF.
REQ-025 REQUEST: TxRequest=1 and TxData=head; TxRequest SHALL be held until TxTaken=1, then go to WAIT_DONE with the timeout counter cleared.
REQ-026 WAIT_DONE: TxRequest=0; on TransmitDone=1, pop the head and go to IDLE.
REQ-027 WAIT_DONE timeout: if the counter reaches DONE_TIMEOUT-1 without TransmitDone, go to DROP.
REQ-028 If TransmitDone and the timeout coincide, TransmitDone SHALL win.
REQ-029 DROP: pop the head, pulse Dropped=1 for exactly one cycle, and go to IDLE.
REQ-030 TxRequest SHALL be registered and SHALL be asserted only in REQUEST; TxTaken and TransmitDone SHALL be ignored in all other states.
REQ-031 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advancing every cycle while not in reset.
REQ-032 Minimum latency from a push into an empty queue to TxRequest=1 SHALL be: 1 cycle to IDLE, then backoff, then 1 SENSE cycle, then the REQUEST register.

Reset
REQ-033 While Reset=1, on the rising edge: State=IDLE, queue empty, QueueCount=0, TxRequest=0, Dropped=0, TxData=0, counters=0, LFSR=16'hACE1.
REQ-034 MsgReady SHALL be 0 while Reset=1.
REQ-035 Reset mid-operation SHALL discard all queued messages, and TxRequest SHALL be 0 from the following edge; no Dropped pulse SHALL be produced.

Configuration
REQ-036 Macro TX_SCHED_CSMA_EN defined: CSMA backoff and CCA sensing operate per REQ-021 to REQ-024.
REQ-037 Macro TX_SCHED_CSMA_EN undefined: IDLE goes directly to REQUEST when QueueCount != 0; CCA is ignored; BACKOFF and SENSE are unreachable; the LFSR and attempt logic SHALL be omitted; DROP is reachable only via timeout.

Verification (BACKOFF_UNIT=4, MAX_ATTEMPTS=3, DONE_TIMEOUT=32, TX_SCHED_CSMA_EN defined unless stated)
REQ-038 Push 32'h12345678, CCA=1, TxTaken pulses 2 cycles after TxRequest, TransmitDone 10 cycles later -> TxData=32'h12345678 while TxRequest=1; QueueCount returns to 0; Dropped never pulses.
REQ-039 Push one message, CCA=0 throughout -> 3 SENSE visits, then a single Dropped pulse; QueueCount=0; TxRequest never asserts.
REQ-040 Push 32'hAAAA0001, 32'hBBBB0002 and 32'hCCCC0003 back-to-back while idle -> the third is refused (MsgReady=0); the first two are transmitted in order.
REQ-041 CCA=1 and TxTaken, but no TransmitDone -> Dropped pulses 32 cycles after entry to WAIT_DONE; State=IDLE.
REQ-042 Reset asserted for 1 cycle during WAIT_DONE with QueueCount=2 -> QueueCount=0, State=0 and TxRequest=0 on the next edge; no Dropped pulse.
REQ-043 TX_SCHED_CSMA_EN undefined, CCA=0 -> TxRequest asserts 2 cycles after the push.

Source files
------------

// File: rtl/tx_scheduler.sv
// Two-entry message queue feeding a transmit FSM, with request/timeout handling.
// Define TX_SCHED_CSMA_EN to add LFSR random backoff and CCA-gated sensing before each request.
module tx_scheduler #(
  parameter int BACKOFF_UNIT = 512,
  parameter int MAX_ATTEMPTS = 4,
  parameter int DONE_TIMEOUT = 65536
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] MsgData,
  input  logic        MsgValid,
  output logic        MsgReady,
  input  logic        CCA,
  output logic        TxRequest,
  output logic [31:0] TxData,
  input  logic        TxTaken,
  input  logic        TransmitDone,
  output logic        Dropped,
  output logic [1:0]  QueueCount,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BACKOFF   = 3'd1,
    SENSE     = 3'd2,
    REQUEST   = 3'd3,
    WAIT_DONE = 3'd4,
    DROP      = 3'd5
  } state_t;

  localparam int TW = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;

  state_t        state;
  logic [31:0]   head;
  logic [31:0]   tail;
  logic [1:0]    count;
  logic [TW-1:0] tmo_cnt;
  logic          push;
  logic          pop;

  assign MsgReady   = !Reset && (count != 2'd2);
  assign push       = MsgValid && MsgReady;
  assign pop        = (count != 2'd0) &&
                      ((state == DROP) || ((state == WAIT_DONE) && TransmitDone));
  assign QueueCount = count;
  assign TxData     = head;
  assign State      = state;

  // head always holds the oldest entry; a simultaneous push/pop can only happen with one entry queued
  always_ff @(posedge Clock) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= MsgData;
          else               tail <= MsgData;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          head <= (count == 2'd1) ? MsgData : tail;
          tail <= MsgData;
        end
        default: ;
      endcase
    end
  end

`ifdef TX_SCHED_CSMA_EN
  localparam int BW = $clog2(8 * BACKOFF_UNIT);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);

  logic [15:0]   lfsr;
  logic [BW-1:0] bo_cnt;
  logic [BW-1:0] bo_load;
  logic [AW-1:0] attempts;

  assign bo_load = BW'((32'(lfsr[2:0]) + 32'd1) * 32'(BACKOFF_UNIT) - 32'd1);

  // Fibonacci form, taps 16,14,13,11, shifting toward bit 0
  always_ff @(posedge Clock) begin
    if (Reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
`else
  logic unused_cca;
  assign unused_cca = CCA;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      TxRequest <= 1'b0;
      Dropped   <= 1'b0;
      tmo_cnt   <= '0;
`ifdef TX_SCHED_CSMA_EN
      bo_cnt    <= '0;
      attempts  <= '0;
`endif
    end else begin
      TxRequest <= 1'b0;
      Dropped   <= 1'b0;
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
`ifdef TX_SCHED_CSMA_EN
            state    <= BACKOFF;
            attempts <= '0;
            bo_cnt   <= bo_load;
`else
            state     <= REQUEST;
            TxRequest <= 1'b1;
`endif
          end
        end
`ifdef TX_SCHED_CSMA_EN
        BACKOFF: begin
          if (bo_cnt == '0) state <= SENSE;
          else              bo_cnt <= bo_cnt - BW'(1);
        end
        SENSE: begin
          if (CCA) begin
            state     <= REQUEST;
            TxRequest <= 1'b1;
          end else if (32'(attempts) + 32'd1 == 32'(MAX_ATTEMPTS)) begin
            state   <= DROP;
            Dropped <= 1'b1;
          end else begin
            attempts <= attempts + AW'(1);
            bo_cnt   <= bo_load;
            state    <= BACKOFF;
          end
        end
`endif
        REQUEST: begin
          if (TxTaken) begin
            state   <= WAIT_DONE;
            tmo_cnt <= '0;
          end else begin
            TxRequest <= 1'b1;
          end
        end
        // completion is checked first so it beats a coincident timeout
        WAIT_DONE: begin
          if (TransmitDone) begin
            state <= IDLE;
          end else if (32'(tmo_cnt) == 32'(DONE_TIMEOUT - 1)) begin
            state   <= DROP;
            Dropped <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DROP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Randomized self-checking bench for tx_scheduler; the reference predicts event cycles
// arithmetically from the backoff/timeout rules and tracks queue contents in a queue.
`timescale 1ns/1ps
module tb_tx_scheduler;
  localparam int BU = 4;
  localparam int MA = 3;
  localparam int DT = 32;
`ifdef TX_SCHED_CSMA_EN
  localparam bit CSMA = 1'b1;
`else
  localparam bit CSMA = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] MsgData = '0;
  logic        MsgValid = 1'b0;
  logic        MsgReady;
  logic        CCA = 1'b0;
  logic        TxRequest;
  logic [31:0] TxData;
  logic        TxTaken = 1'b0;
  logic        TransmitDone = 1'b0;
  logic        Dropped;
  logic [1:0]  QueueCount;
  logic [2:0]  State;

  tx_scheduler #(.BACKOFF_UNIT(BU), .MAX_ATTEMPTS(MA), .DONE_TIMEOUT(DT)) dut (
    .Clock(Clock), .Reset(Reset), .MsgData(MsgData), .MsgValid(MsgValid),
    .MsgReady(MsgReady), .CCA(CCA), .TxRequest(TxRequest), .TxData(TxData),
    .TxTaken(TxTaken), .TransmitDone(TransmitDone), .Dropped(Dropped),
    .QueueCount(QueueCount), .State(State)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int rst_edge = 0;
  int rise_cnt = 0, rise_cyc = -1;
  int drop_cnt = 0, drop_cyc = -1;
  int sense_cnt = 0;
  int exp_drops = 0;
  logic req_prev = 1'b0;
  logic [31:0] mq[$];

  // cycle c is the interval following rising edge number c
  always @(posedge Clock) begin
    cyc++;
    if (Reset) rst_edge = cyc;
  end

  always @(negedge Clock) begin
    if (TxRequest && !req_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    req_prev = TxRequest;
    if (Dropped) begin
      drop_cnt++;
      drop_cyc = cyc;
    end
    if (State == 3'd2) sense_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // backoff slots chosen in cycle c: generator stepped once per cycle since reset
  function automatic int slots_at(int c);
    int l = 'hACE1;
    for (int n = 0; n < c - rst_edge; n++)
      l = (l >> 1) | (((l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1) << 15);
    return (l % 8) + 1;
  endfunction

  // i = cycle in which the idle scheduler first sees a non-empty queue
  function automatic int predict_req(int i);
    return CSMA ? i + 2 + slots_at(i) * BU : i + 1;
  endfunction

  function automatic int predict_drop(int i);
    int s = i + 1 + slots_at(i) * BU;
    for (int a = 1; a < MA; a++) s = s + 1 + slots_at(s) * BU;
    return s + 1;
  endfunction

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic wait_to(input int target);
    int guard = 0;
    while (cyc < target && guard < 4000) begin
      step();
      guard++;
    end
    if (cyc < target) check("wait_bound", cyc, target);
  endtask

  task automatic push(input logic [31:0] d);
    check("msg_ready", MsgReady, (mq.size() != 2));
    MsgValid = 1'b1;
    MsgData  = d;
    if (mq.size() < 2) mq.push_back(d);
    step();
    MsgValid = 1'b0;
  endtask

  task automatic serve(input int i, input bit cca_ok, input int td, input int dd,
                       input bit push_mid, input logic [31:0] pd, output int next_i);
    int target, e, s0, r0, hold_bad;
    bit full;
    CCA = cca_ok;
    s0 = sense_cnt;
    r0 = rise_cnt;
    if (!cca_ok && CSMA) begin
      target = predict_drop(i);
      wait_to(target);
      check("drop_cycle", drop_cyc, target);
      exp_drops++;
      check("drop_count", drop_cnt, exp_drops);
      check("sense_visits", sense_cnt - s0, MA);
      check("no_request", rise_cnt, r0);
      void'(mq.pop_front());
      step();
      check("drop_width", drop_cnt, exp_drops);
      check("count_after_drop", QueueCount, mq.size());
      next_i = cyc;
    end else begin
      target = predict_req(i);
      wait_to(target);
      check("req_cycle", rise_cyc, target);
      check("sense_before_req", sense_cnt - s0, CSMA ? 1 : 0);
      check("tx_data", TxData, mq[0]);
      hold_bad = 0;
      for (int k = 0; k < td; k++) begin
        step();
        if (!TxRequest) hold_bad++;
      end
      check("req_hold", hold_bad, 0);
      TxTaken = 1'b1;
      step();
      TxTaken = 1'b0;
      check("req_clear", TxRequest, 0);
      e = cyc;
      if (dd < DT) begin
        wait_to(e + dd);
        TransmitDone = 1'b1;
        full = (mq.size() == 2);
        if (push_mid) begin
          check("ready_mid", MsgReady, !full);
          MsgValid = 1'b1;
          MsgData  = pd;
        end
        step();
        TransmitDone = 1'b0;
        MsgValid = 1'b0;
        void'(mq.pop_front());
        if (push_mid && !full) mq.push_back(pd);
        check("count_after_done", QueueCount, mq.size());
        check("no_drop_on_done", drop_cnt, exp_drops);
        next_i = cyc;
      end else begin
        wait_to(e + DT);
        check("timeout_cycle", drop_cyc, e + DT);
        exp_drops++;
        void'(mq.pop_front());
        step();
        check("timeout_drops", drop_cnt, exp_drops);
        check("state_after_timeout", State, 0);
        check("count_after_timeout", QueueCount, mq.size());
        next_i = cyc;
      end
    end
  endtask

  initial begin
    int ni, p, r0, guard, serves;
    bit cca;

    step();
    check("ready_in_reset", MsgReady, 0);
    step();
    check("rst_state", State, 0);
    check("rst_count", QueueCount, 0);
    check("rst_req", TxRequest, 0);
    check("rst_drop", Dropped, 0);
    check("rst_txdata", TxData, 0);
    Reset = 1'b0;
    step();
    check("ready_after_reset", MsgReady, 1);

    // single clean transmission
    CCA = 1'b1;
    p = cyc;
    push(32'h12345678);
    serve(p + 1, 1'b1, 2, 9, 1'b0, 32'h0, ni);

    // busy channel: dropped after retries with CSMA, immediate request without
    p = cyc;
    push(32'h0BADCAFE);
    serve(p + 1, 1'b0, 1, 5, 1'b0, 32'h0, ni);

    // third back-to-back push is refused, first two go out in order
    CCA = 1'b1;
    p = cyc;
    push(32'hAAAA0001);
    push(32'hBBBB0002);
    push(32'hCCCC0003);
    serve(p + 1, 1'b1, 0, 3, 1'b0, 32'h0, ni);
    serve(ni, 1'b1, 1, 4, 1'b0, 32'h0, ni);

    // timeout, then completion landing on the timeout cycle
    p = cyc;
    push(32'h5A5A0004);
    serve(p + 1, 1'b1, 1, DT + 5, 1'b0, 32'h0, ni);
    p = cyc;
    push(32'h5A5A0005);
    serve(p + 1, 1'b1, 0, DT - 1, 1'b0, 32'h0, ni);

    // push in the same cycle as the pop keeps order
    p = cyc;
    push(32'h11110006);
    serve(p + 1, 1'b1, 0, 2, 1'b1, 32'h22220007, ni);
    serve(ni, 1'b1, 0, 1, 1'b0, 32'h0, ni);

    // reset while waiting for completion with two queued
    p = cyc;
    push(32'h33330008);
    push(32'h44440009);
    guard = 0;
    while (!TxRequest && guard < 400) begin
      step();
      guard++;
    end
    check("req_before_reset", TxRequest, 1);
    TxTaken = 1'b1;
    step();
    TxTaken = 1'b0;
    step();
    step();
    check("count_before_reset", QueueCount, 2);
    r0 = rise_cnt;
    Reset = 1'b1;
    #1;
    check("ready_in_reset_mid", MsgReady, 0);
    step();
    Reset = 1'b0;
    mq.delete();
    check("rst_mid_count", QueueCount, 0);
    check("rst_mid_state", State, 0);
    check("rst_mid_req", TxRequest, 0);
    repeat (40) step();
    check("rst_mid_no_drop", drop_cnt, exp_drops);
    check("rst_mid_no_req", rise_cnt, r0);

    // completion/taken pulses while idle must be ignored
    TxTaken = 1'b1;
    TransmitDone = 1'b1;
    step();
    TxTaken = 1'b0;
    TransmitDone = 1'b0;
    step();
    check("stray_state", State, 0);
    check("stray_req", TxRequest, 0);
    check("stray_count", QueueCount, 0);

    for (int it = 0; it < 12; it++) begin
      p = cyc;
      push($urandom);
      if ($urandom_range(0, 1) == 1) push($urandom);
      ni = p + 1;
      serves = 0;
      while (mq.size() != 0 && serves < 8) begin
        cca = CSMA ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
        serve(ni, cca, $urandom_range(0, 3), $urandom_range(0, 40),
              ($urandom_range(0, 2) == 0), $urandom, ni);
        serves++;
      end
      if (mq.size() != 0) begin
        check("random_drain", mq.size(), 0);
        mq.delete();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
      end
      repeat ($urandom_range(0, 3)) step();
    end
    check("final_count", QueueCount, 0);
    check("final_drops", drop_cnt, exp_drops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
